// File: rtl/inst_sram_bridge_pkg.sv
// -----------------------------------------------------------------------------
// inst_sram_bridge_pkg
// Shared definitions for the instruction-fetch SRAM bridge:
//   - default address/data bus widths
//   - 3-bit FSM state encoding
// -----------------------------------------------------------------------------
package inst_sram_bridge_pkg;

    localparam int ADDR_WD_DEF = 32;
    localparam int DATA_WD_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_DONE    = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

endpackage

// File: rtl/inst_sram_bridge.sv
// -----------------------------------------------------------------------------
// inst_sram_bridge
// Converts the fetch pipeline's SRAM-style instruction port into a single
// outstanding request/response read on the memory side.
//
// Ports
//   clk, resetn        : clock, synchronous active-low reset
//   flush              : pipeline redirect; cancels the fetch in flight
//   inst_sram_en       : fetch request valid
//   inst_sram_we       : write strobe (ignored, port is read-only)
//   inst_sram_addr     : fetch byte address
//   inst_sram_wdata    : write data (ignored)
//   inst_sram_rdata    : returned instruction word (valid in DONE)
//   stallreq           : holds the fetch stages while a fetch is pending
//   mem_req/mem_addr   : memory read request and word-aligned address
//   mem_addr_ok        : request accepted (handshake = mem_req & mem_addr_ok)
//   mem_data_ok        : read data valid, one pulse per accepted request
//   mem_rdata          : read data
//
// Handshake: the memory-side request transfers on a rising edge where
// mem_req and mem_addr_ok are both high; mem_req, once raised, stays high
// with a stable mem_addr until that transfer (or a flush drops it). Each
// transferred request returns exactly one mem_data_ok pulse, in order.
// -----------------------------------------------------------------------------
module inst_sram_bridge
    import inst_sram_bridge_pkg::*;
#(
    parameter int ADDR_WD = ADDR_WD_DEF,
    parameter int DATA_WD = DATA_WD_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               inst_sram_en,
    input  logic [3:0]         inst_sram_we,
    input  logic [ADDR_WD-1:0] inst_sram_addr,
    input  logic [DATA_WD-1:0] inst_sram_wdata,
    output logic [DATA_WD-1:0] inst_sram_rdata,
    output logic               stallreq,
    output logic               mem_req,
    output logic [ADDR_WD-1:0] mem_addr,
    input  logic               mem_addr_ok,
    input  logic               mem_data_ok,
    input  logic [DATA_WD-1:0] mem_rdata
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_capture;
    logic [ADDR_WD-1:0] r_addr;
    logic [DATA_WD-1:0] r_data;

    // Write-side inputs and the byte-offset bits are intentionally dropped.
    logic w_unused_ok;
    assign w_unused_ok = ^{inst_sram_we, inst_sram_wdata, inst_sram_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr <= {inst_sram_addr[ADDR_WD-1:2], 2'b00};
            end
            if (w_capture) begin
                r_data <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (inst_sram_en && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // A flush racing an accepted request still owes us one
                // data_ok pulse, so it must be absorbed in DISCARD.
                if (flush) begin
                    w_state_nxt = mem_addr_ok ? S_DISCARD : S_IDLE;
                end else if (mem_addr_ok) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_state_nxt = mem_data_ok ? S_IDLE : S_DISCARD;
                end else if (mem_data_ok) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Accepting straight from DONE keeps back-to-back fetches
                // free of an IDLE bubble.
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (inst_sram_en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (mem_data_ok) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        stallreq = 1'b0;
        case (r_state)
            S_REQ: begin
                mem_req  = 1'b1;
                stallreq = 1'b1;
            end
            S_WAIT: begin
                stallreq = 1'b1;
            end
            S_DISCARD: begin
                stallreq = inst_sram_en;
            end
            default: begin
                mem_req  = 1'b0;
                stallreq = 1'b0;
            end
        endcase
    end

    assign mem_addr        = r_addr;
    assign inst_sram_rdata = r_data;

endmodule

// File: tb/tb_inst_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_inst_sram_bridge
// Directed bench for inst_sram_bridge. The driver pushes expected memory
// addresses and instruction words into queues; a monitor pops them when the
// DUT performs a memory handshake or presents a returned word.
// -----------------------------------------------------------------------------
module tb_inst_sram_bridge;
    import inst_sram_bridge_pkg::*;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        stallreq;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int          n_checks;
    int          n_errors;
    logic [31:0] last_good;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    inst_sram_bridge dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .stallreq        (stallreq),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_addr_ok     (mem_addr_ok),
        .mem_data_ok     (mem_data_ok),
        .mem_rdata       (mem_rdata)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        inst_sram_we    = 4'($urandom);
        inst_sram_wdata = $urandom;
    endtask

    // Fetch accepted from IDLE; hs says whether a memory handshake will follow.
    task automatic accept(input logic [31:0] addr, input bit hs);
        logic [31:0] aligned;
        aligned       = addr;
        aligned[1:0]  = 2'b00;
        flush         = 1'b0;
        inst_sram_en  = 1'b1;
        inst_sram_addr = addr;
        if (hs) exp_addr_q.push_back(aligned);
        mid();
        chk("accept_stall", stallreq, 1'b0);
        chk("accept_req", mem_req, 1'b0);
        chk("accept_rdata_hold", inst_sram_rdata, last_good);
        nxt();
        inst_sram_en   = 1'b0;
        inst_sram_addr = $urandom;
    endtask

    // REQ .. DONE of one fetch. In the DONE cycle the fetch side presents
    // done_en/done_addr/done_flush.
    task automatic body(input logic [31:0] ea, input int aw, input int dw,
                        input logic [31:0] data, input bit done_en,
                        input logic [31:0] done_addr, input bit done_flush);
        logic [31:0] aligned;
        for (int i = 0; i <= aw; i++) begin
            mem_addr_ok = (i == aw);
            mid();
            chk("req_mem_req", mem_req, 1'b1);
            chk("req_mem_addr", mem_addr, ea);
            chk("req_stall", stallreq, 1'b1);
            nxt();
        end
        mem_addr_ok = 1'b0;
        for (int i = 0; i < dw; i++) begin
            mid();
            chk("wait_mem_req", mem_req, 1'b0);
            chk("wait_stall", stallreq, 1'b1);
            nxt();
        end
        mem_data_ok = 1'b1;
        mem_rdata   = data;
        exp_data_q.push_back(data);
        mid();
        chk("dok_mem_req", mem_req, 1'b0);
        chk("dok_stall", stallreq, 1'b1);
        nxt();
        mem_data_ok    = 1'b0;
        mem_rdata      = $urandom;
        inst_sram_en   = done_en;
        inst_sram_addr = done_addr;
        flush          = done_flush;
        aligned        = done_addr;
        aligned[1:0]   = 2'b00;
        if (done_en && !done_flush) exp_addr_q.push_back(aligned);
        mid();
        chk("done_stall", stallreq, 1'b0);
        chk("done_mem_req", mem_req, 1'b0);
        chk("done_rdata", inst_sram_rdata, data);
        last_good = data;
        nxt();
        inst_sram_en = 1'b0;
        flush        = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && mem_req && mem_addr_ok) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_mem_addr: unexpected handshake addr %h expected none", mem_addr);
                end else begin
                    chk("sb_mem_addr", mem_addr, exp_addr_q.pop_front());
                end
            end
            if (dut.r_state == S_DONE) begin
                if (exp_data_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_rdata: unexpected word %h expected none", inst_sram_rdata);
                end else begin
                    chk("sb_rdata", inst_sram_rdata, exp_data_q.pop_front());
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        n_checks        = 0;
        n_errors        = 0;
        last_good       = 32'h0;
        resetn          = 1'b0;
        flush           = 1'b0;
        inst_sram_en    = 1'b0;
        inst_sram_we    = 4'h0;
        inst_sram_addr  = 32'h0;
        inst_sram_wdata = 32'h0;
        mem_addr_ok     = 1'b0;
        mem_data_ok     = 1'b0;
        mem_rdata       = 32'h0;

        // reset state
        nxt();
        nxt();
        mid();
        chk("rst_stall", stallreq, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_rdata", inst_sram_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        nxt();
        resetn = 1'b1;
        nxt();

        // minimum-latency fetch
        accept(32'h1C00_0000, 1'b1);
        body(32'h1C00_0000, 0, 0, 32'h0280_0C0C, 1'b0, 32'h0, 1'b0);

        // unaligned address is word-aligned
        accept(32'h1C00_0006, 1'b1);
        body(32'h1C00_0004, 0, 0, 32'h0010_0113, 1'b0, 32'h0, 1'b0);

        // addr_ok held low 4 cycles, data_ok 3 cycles after acceptance
        accept(32'h1C00_0008, 1'b1);
        body(32'h1C00_0008, 4, 2, 32'h1234_5678, 1'b0, 32'h0, 1'b0);

        // flush in WAIT, new request during DISCARD, stale data dropped
        accept(32'h1C00_000C, 1'b1);
        mem_addr_ok = 1'b1;
        mid();
        chk("t4_req", mem_req, 1'b1);
        nxt();
        mem_addr_ok = 1'b0;
        flush = 1'b1;
        mid();
        chk("t4_wait_stall", stallreq, 1'b1);
        nxt();
        flush          = 1'b0;
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'h1C00_0100;
        mid();
        chk("t4_disc_stall", stallreq, 1'b1);
        chk("t4_disc_req", mem_req, 1'b0);
        chk("t4_disc_rdata", inst_sram_rdata, last_good);
        nxt();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hDEAD_BEEF;
        mid();
        chk("t4_stale_stall", stallreq, 1'b1);
        chk("t4_stale_req", mem_req, 1'b0);
        nxt();
        mem_data_ok = 1'b0;
        accept(32'h1C00_0100, 1'b1);
        body(32'h1C00_0100, 1, 1, 32'h0000_0013, 1'b1, 32'h1C00_0200, 1'b0);

        // back-to-back from DONE, then flush in DONE drops the next request
        body(32'h1C00_0200, 0, 0, 32'hAAAA_5555, 1'b1, 32'h1C00_0300, 1'b1);
        mid();
        chk("t5_idle_req", mem_req, 1'b0);
        chk("t5_idle_stall", stallreq, 1'b0);
        nxt();

        // flush in REQ with addr_ok low: request dropped
        accept(32'h1C00_0400, 1'b0);
        flush = 1'b1;
        mid();
        chk("t6_req", mem_req, 1'b1);
        nxt();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t6_idle_req", mem_req, 1'b0);
            chk("t6_idle_stall", stallreq, 1'b0);
            chk("t6_idle_rdata", inst_sram_rdata, last_good);
            nxt();
        end

        // flush in REQ with addr_ok high: discard the owed data
        accept(32'h1C00_0500, 1'b1);
        flush       = 1'b1;
        mem_addr_ok = 1'b1;
        mid();
        nxt();
        flush       = 1'b0;
        mem_addr_ok = 1'b0;
        mid();
        chk("t7_disc_stall_en0", stallreq, 1'b0);
        chk("t7_disc_req", mem_req, 1'b0);
        nxt();
        inst_sram_en = 1'b1;
        mid();
        chk("t7_disc_stall_en1", stallreq, 1'b1);
        nxt();
        inst_sram_en = 1'b0;
        mem_data_ok  = 1'b1;
        mem_rdata    = 32'hBAD0_BAD0;
        mid();
        nxt();
        mem_data_ok = 1'b0;
        mid();
        chk("t7_idle_stall", stallreq, 1'b0);
        chk("t7_idle_rdata", inst_sram_rdata, last_good);
        nxt();

        // flush in WAIT together with data_ok: data dropped, straight to IDLE
        accept(32'h1C00_0600, 1'b1);
        mem_addr_ok = 1'b1;
        mid();
        nxt();
        mem_addr_ok = 1'b0;
        flush       = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hCAFE_F00D;
        mid();
        nxt();
        flush       = 1'b0;
        mem_data_ok = 1'b0;
        mid();
        chk("t8_idle_req", mem_req, 1'b0);
        chk("t8_idle_stall", stallreq, 1'b0);
        chk("t8_idle_rdata", inst_sram_rdata, last_good);
        nxt();
        accept(32'h1C00_0700, 1'b1);
        body(32'h1C00_0700, 0, 0, 32'h0000_0700, 1'b0, 32'h0, 1'b0);

        // reset mid-transaction in WAIT
        accept(32'h1C00_0800, 1'b1);
        mem_addr_ok = 1'b1;
        mid();
        nxt();
        mem_addr_ok = 1'b0;
        resetn = 1'b0;
        mid();
        chk("t9_wait_stall", stallreq, 1'b1);
        nxt();
        resetn = 1'b1;
        mid();
        chk("t9_rst_req", mem_req, 1'b0);
        chk("t9_rst_stall", stallreq, 1'b0);
        chk("t9_rst_rdata", inst_sram_rdata, 32'h0);
        chk("t9_rst_addr", mem_addr, 32'h0);
        last_good = 32'h0;
        nxt();
        accept(32'h1C00_0900, 1'b1);
        body(32'h1C00_0900, 0, 1, 32'h5A5A_A5A5, 1'b0, 32'h0, 1'b0);

        repeat (3) nxt();
        chk("sb_addr_q_empty", exp_addr_q.size(), 32'd0);
        chk("sb_data_q_empty", exp_data_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
